udp_tx_sched: RTL
=================

UDP_TX_SCHED -- requirements
Module: udp_tx_sched

Interface
REQ-001 SHALL have parameter DATA_W, default 7680 (960 bytes x 8), meaning the payload bus width.
REQ-002 SHALL have parameter MAX_LEN, default 16'd960, meaning the largest legal byte length.
REQ-003 SHALL have parameter GAP_CYC, default 16, meaning the minimum idle cycles between frames.
REQ-004 SHALL have parameter TIMEOUT_CYC, default 32'd5_000_000, meaning the cycles allowed for a done flag (100 ms at 50 MHz).
REQ-005 SHALL have parameter PRIO_FIXED, default 0: 1 = requester 0 always wins; 0 = round-robin.
REQ-006 SHALL have port clk, input, 1 bit: the 50 MHz system clock, with all logic on its rising edge.
REQ-007 SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-008 SHALL have ports req0_valid/req1_valid, input, 1 bit each: frame pending; held until the matching ack.
REQ-009 SHALL have ports req0_data/req1_data, input, DATA_W each: the payload, with byte 0 at the MSBs.
REQ-010 SHALL have ports req0_len/req1_len, input, 16 bits each: the payload length in bytes.
REQ-011 SHALL have ports req0_ack/req1_ack, output, 1 bit each: a 1-cycle pulse meaning the frame was captured or dropped.
REQ-012 SHALL have port udp_send_data_valid, output, 1 bit: a frame is offered to the UDP core.
REQ-013 SHALL have port udp_send_data, output, DATA_W: the registered payload.
REQ-014 SHALL have port udp_send_data_length, output, 16 bits: the registered length.
REQ-015 SHALL have port udp_send_data_ready, input, 1 bit: a 1-cycle done flag from the UDP core.
REQ-016 SHALL have port tx_done, output, 1 bit: a 1-cycle pulse when a frame completes or is aborted.
REQ-017 SHALL have port tx_src, output, 1 bit: the source of the current or last frame.
REQ-018 SHALL have port busy, output, 1 bit: high in every state except IDLE.
REQ-019 SHALL have ports err_timeout/err_len, output, 1 bit each: sticky error flags.
REQ-020 SHALL have port frame_cnt, output, 16 bits: the count of completed frames; it wraps at FFFF to 0000.

Function
REQ-021 SHALL implement the FSM states IDLE, LOAD, SEND, GAP.
REQ-022 IDLE: when any reqN_valid is high, SHALL select the winner and go to LOAD on the next edge.
REQ-023 Round-robin SHALL grant the requester other than last_src when both requesters are valid; last_src resets to 1, so requester 0 wins first.
REQ-024 LOAD: SHALL register the winner's data and length, set tx_src, and pulse that requester's ack in this cycle.
REQ-025 LOAD: if len==0 or len>MAX_LEN, SHALL drop the frame (ack pulse, set err_len, no valid) and go to IDLE.
REQ-026 LOAD: otherwise SHALL go to SEND, and udp_send_data_valid SHALL rise in the first SEND cycle (2 cycles after the request is seen).
REQ-027 SEND: valid, data and length SHALL stay stable until udp_send_data_ready=1.
REQ-028 On ready in SEND, SHALL drop valid on the next edge, pulse tx_done, increment frame_cnt, and enter GAP.
REQ-029 udp_send_data_ready outside SEND SHALL be ignored, with no count and no pulse.
REQ-030 SEND timeout: a 32-bit counter SHALL clear on SEND entry; on reaching TIMEOUT_CYC-1 it SHALL drop valid, set err_timeout, pulse tx_done, leave frame_cnt unchanged, and enter GAP.
REQ-031 GAP: SHALL hold valid low for exactly GAP_CYC cycles, then return to IDLE.
REQ-032 GAP: requests arriving during GAP SHALL wait with no ack.
REQ-033 Requester contract: reqN_data and reqN_len SHALL be stable while reqN_valid is high; a valid dropped before ack is legal, and nothing is captured.
REQ-034 last_src SHALL update in LOAD for both accepted and dropped frames.
REQ-035 err_timeout and err_len SHALL clear only on reset.

Reset
REQ-036 On rst: state=IDLE, last_src=1, all outputs 0, and the payload register SHALL be 0.
REQ-037 rst asserted mid-SEND SHALL drop valid at once; there SHALL be no ack, no tx_done pulse and no frame_cnt change.
REQ-038 Release: IDLE SHALL respond on the first clk edge after rst deasserts.

Structure
REQ-039 A shared package SHALL hold the state encoding (2-bit) and the defaults for MAX_LEN, GAP_CYC and TIMEOUT_CYC.
REQ-040 The grant logic SHALL be one sub-module, rr_arb2: inputs req[1:0] and last, output gnt_idx.
REQ-041 The design SHALL have one clock domain and no FIFOs; RTP and UDP framing stay outside this block.

Verification
REQ-042 Single frame: req0, len 960 -> ack0 in cycle 1, valid in cycle 2; ready 10 cycles later -> tx_done, frame_cnt=1, valid low 16 cycles.
REQ-043 Contention: req0 and req1 held, 4 frames -> sources 0,1,0,1; with PRIO_FIXED=1 -> 0,0,0,0.
REQ-044 Bad length: len=0, then len=961 -> both acked, no valid, err_len=1, frame_cnt=0.
REQ-045 Timeout: TIMEOUT_CYC=100, no ready -> valid drops after 100 cycles, err_timeout=1, tx_done pulses, frame_cnt unchanged.
REQ-046 Reset mid-SEND, then a stray ready in IDLE -> state IDLE, outputs 0, frame_cnt=0, no tx_done.
REQ-047 Wrap: preload 16'hFFFF, one frame -> frame_cnt=0.

Source files
------------

// File: rtl/udp_tx_sched_pkg.sv
// rtl/udp_tx_sched_pkg.sv - shared state encoding and parameter defaults for udp_tx_sched
package udp_tx_sched_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_SEND = 2'd2,
    ST_GAP  = 2'd3
  } state_t;

  localparam logic [15:0] DEF_MAX_LEN     = 16'd960;
  localparam int          DEF_GAP_CYC     = 16;
  localparam logic [31:0] DEF_TIMEOUT_CYC = 32'd5_000_000;

endpackage

// File: rtl/rr_arb2.sv
// rtl/rr_arb2.sv - two-requester grant: fixed priority to 0, or round-robin against last
module rr_arb2 #(
  parameter int PRIO_FIXED = 0
) (
  input  logic [1:0] req,
  input  logic       last,
  output logic       gnt_idx
);

  always_comb begin
    gnt_idx = 1'b0;
    if (PRIO_FIXED != 0) begin
      gnt_idx = ~req[0];
    end else if (req == 2'b11) begin
      gnt_idx = ~last;
    end else begin
      gnt_idx = req[1];
    end
  end

endmodule

// File: rtl/udp_tx_sched.sv
// rtl/udp_tx_sched.sv - arbitrates two frame requesters onto one UDP send port
module udp_tx_sched
  import udp_tx_sched_pkg::*;
#(
  parameter int          DATA_W      = 7680,
  parameter logic [15:0] MAX_LEN     = DEF_MAX_LEN,
  parameter int          GAP_CYC     = DEF_GAP_CYC,
  parameter logic [31:0] TIMEOUT_CYC = DEF_TIMEOUT_CYC,
  parameter int          PRIO_FIXED  = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0_valid,
  input  logic              req1_valid,
  input  logic [DATA_W-1:0] req0_data,
  input  logic [DATA_W-1:0] req1_data,
  input  logic [15:0]       req0_len,
  input  logic [15:0]       req1_len,
  output logic              req0_ack,
  output logic              req1_ack,
  output logic              udp_send_data_valid,
  output logic [DATA_W-1:0] udp_send_data,
  output logic [15:0]       udp_send_data_length,
  input  logic              udp_send_data_ready,
  output logic              tx_done,
  output logic              tx_src,
  output logic              busy,
  output logic              err_timeout,
  output logic              err_len,
  output logic [15:0]       frame_cnt
);

  state_t      state, state_nx;
  logic        sel, last_src, gnt_idx;
  logic        sel_valid, len_bad, timeout_hit;
  logic [15:0] sel_len;
  logic [31:0] to_cnt;
  logic [15:0] gap_cnt;

  rr_arb2 #(.PRIO_FIXED(PRIO_FIXED)) u_arb (
    .req     ({req1_valid, req0_valid}),
    .last    (last_src),
    .gnt_idx (gnt_idx)
  );

  assign sel_valid   = sel ? req1_valid : req0_valid;
  assign sel_len     = sel ? req1_len : req0_len;
  assign len_bad     = (sel_len == 16'd0) || (sel_len > MAX_LEN);
  assign timeout_hit = (to_cnt == TIMEOUT_CYC - 32'd1);

  // A requester that withdrew before LOAD gets no ack and nothing is captured.
  assign req0_ack            = (state == ST_LOAD) && !sel && req0_valid;
  assign req1_ack            = (state == ST_LOAD) &&  sel && req1_valid;
  assign udp_send_data_valid = (state == ST_SEND);
  assign busy                = (state != ST_IDLE);

  always_comb begin
    state_nx = state;
    unique case (state)
      ST_IDLE: if (req0_valid || req1_valid) state_nx = ST_LOAD;
      ST_LOAD: state_nx = (sel_valid && !len_bad) ? ST_SEND : ST_IDLE;
      ST_SEND: if (udp_send_data_ready || timeout_hit) state_nx = ST_GAP;
      ST_GAP:  if (gap_cnt == 16'(GAP_CYC - 1)) state_nx = ST_IDLE;
      default: state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state                <= ST_IDLE;
      sel                  <= 1'b0;
      last_src             <= 1'b1;
      tx_src               <= 1'b0;
      udp_send_data        <= '0;
      udp_send_data_length <= '0;
      tx_done              <= 1'b0;
      err_timeout          <= 1'b0;
      err_len              <= 1'b0;
      frame_cnt            <= '0;
      to_cnt               <= '0;
      gap_cnt              <= '0;
    end else begin
      state   <= state_nx;
      tx_done <= 1'b0;
      unique case (state)
        ST_IDLE: sel <= gnt_idx;
        ST_LOAD: begin
          to_cnt <= '0;
          if (sel_valid) begin
            last_src <= sel;
            tx_src   <= sel;
            if (len_bad) begin
              err_len <= 1'b1;
            end else begin
              udp_send_data        <= sel ? req1_data : req0_data;
              udp_send_data_length <= sel_len;
            end
          end
        end
        ST_SEND: begin
          to_cnt <= to_cnt + 32'd1;
          // Ready wins over a timeout landing on the same cycle.
          if (udp_send_data_ready) begin
            tx_done   <= 1'b1;
            frame_cnt <= frame_cnt + 16'd1;
            gap_cnt   <= '0;
          end else if (timeout_hit) begin
            tx_done     <= 1'b1;
            err_timeout <= 1'b1;
            gap_cnt     <= '0;
          end
        end
        ST_GAP:  gap_cnt <= gap_cnt + 16'd1;
        default: ;
      endcase
    end
  end

endmodule
